// File: rtl/rv_ctrl_fsm_pkg.sv
// rv_ctrl_fsm_pkg: shared opcodes, FSM state, write-back select and ALU control types
// Ports: none (package)
package rv_ctrl_fsm_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_PC4 = 2'b10, WB_IMM = 2'b11
    } wb_sel_e;

    // four 8-bit ALU control bytes, [0] is the least significant
    typedef logic [3:0][7:0] alu_c_t;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_IMM, OP_OP};
    endfunction
endpackage

// File: rtl/rv_ctrl_fsm_if.sv
// rv_ctrl_fsm_if: instruction- and data-memory handshake bus
// master = control unit (drives req/addr/we), slave = memory side (drives rdata/valid/ready)
interface rv_ctrl_fsm_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_rdata, imem_valid, dmem_ready
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_rdata, imem_valid, dmem_ready
    );
endinterface

// File: rtl/rv_ctrl_fsm_imm_gen.sv
// rv_ctrl_fsm_imm_gen: sign-extended RV32I immediate (I/S/B/U/J) selected by opcode
// instr_i: latched instruction word; imm_o: immediate, 0 for R-type/unknown
module rv_ctrl_fsm_imm_gen
    import rv_ctrl_fsm_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);
    logic [6:0] op;
    assign op = instr_i[6:0];

    always_comb begin
        imm_o = (op == OP_LUI || op == OP_AUIPC) ? {instr_i[31:12], 12'b0} :
                (op == OP_JAL) ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                (op == OP_BRANCH) ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                (op == OP_STORE) ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                (op inside {OP_IMM, OP_LOAD, OP_JALR}) ? {{20{instr_i[31]}}, instr_i[31:20]} :
                32'h0;
    end
endmodule

// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle RV32I control unit (fetch, decode, ALU control, PC sequencing)
// clk/rst_n: clock, synchronous active-low reset
// bus: imem/dmem handshake (master)
// alu_zero_i: branch condition; alu_res_i: ALU result, used as the JALR target
// alu_c_o, src_a_sel_o, src_b_sel_o, imm_o: ALU control; rs1/rs2/rd_o, rf_we_o, wb_sel_o: register file
// pc_o: current PC; illegal_o: sticky unsupported-opcode flag
module rv_ctrl_fsm
    import rv_ctrl_fsm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_ctrl_fsm_if.master      bus,
    input  logic               alu_zero_i,
    input  logic [31:0]        alu_res_i,
    output alu_c_t             alu_c_o,
    output logic               src_a_sel_o,
    output logic               src_b_sel_o,
    output logic [31:0]        imm_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [4:0]         rd_o,
    output logic               rf_we_o,
    output wb_sel_e            wb_sel_o,
    output logic [31:0]        pc_o,
    output logic               illegal_o
);
    state_e      state_q;
    logic [31:0] pc_q, npc_q, instr_q, pc_inc_d, pc_tgt_d;
    logic        imem_req_q, dmem_req_q, illegal_q;
    logic [6:0]  opcode;
    logic        act, force_add;

    rv_ctrl_fsm_imm_gen u_imm (.instr_i(instr_q), .imm_o(imm_o));

    assign opcode    = instr_q[6:0];
    assign rs1_o     = instr_q[19:15];
    assign rs2_o     = instr_q[24:20];
    assign rd_o      = instr_q[11:7];
    assign pc_o      = pc_q;
    assign illegal_o = illegal_q;
    assign pc_inc_d  = pc_q + 32'd4;
    assign pc_tgt_d  = pc_q + imm_o;
    // decode outputs are held through MEM/WB so the datapath can finish the op
    assign act       = state_q inside {S_EXEC, S_MEM, S_WB};
    assign force_add = opcode inside {OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC};

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_req_q && opcode == OP_STORE;

    always_comb begin
        alu_c_o     = act ? {{1'b0, opcode}, {3'b0, instr_q[24:20]}, {1'b0, instr_q[31:25]},
                             {force_add, 4'b0, instr_q[14:12]}} : '0;
        src_a_sel_o = act && (opcode == OP_AUIPC || opcode == OP_JAL);
        src_b_sel_o = act && !(opcode inside {OP_OP, OP_BRANCH});
        wb_sel_o    = !act ? WB_ALU :
                      opcode == OP_LOAD ? WB_LOAD :
                      (opcode == OP_JAL || opcode == OP_JALR) ? WB_PC4 :
                      opcode == OP_LUI ? WB_IMM : WB_ALU;
        rf_we_o     = state_q == S_WB && rd_o != 5'd0;
    end

    // pc only moves when leaving EXEC (branch), MEM (store) or WB, so WB still sees the
    // instruction's own pc for the pc+4 link; npc_q carries the target until then
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC;
            instr_q    <= NOP;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_req_q && bus.imem_valid) begin
                        instr_q    <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    illegal_q <= !is_legal(opcode);
                    state_q   <= is_legal(opcode) ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    npc_q <= opcode == OP_JAL ? pc_tgt_d :
                             opcode == OP_JALR ? (alu_res_i & ~32'd1) : pc_inc_d;
                    if (opcode == OP_BRANCH) begin
                        pc_q       <= alu_zero_i ? pc_tgt_d : pc_inc_d;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        dmem_req_q <= 1'b1;
                        state_q    <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        if (opcode == OP_STORE) begin
                            pc_q       <= npc_q;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc_q       <= npc_q;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                default: state_q <= S_TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// tb_rv_ctrl_fsm: directed scoreboard bench for the RV32I control FSM
module tb_rv_ctrl_fsm;
    import rv_ctrl_fsm_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_res = 32'h0;
    alu_c_t      alu_c;
    logic        src_a_sel, src_b_sel, rf_we, illegal;
    logic [31:0] imm, pc, mpc;
    logic [4:0]  rs1, rs2, rd;
    wb_sel_e     wb_sel;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    rv_ctrl_fsm_if bus();

    rv_ctrl_fsm #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_zero_i(alu_zero), .alu_res_i(alu_res),
        .alu_c_o(alu_c), .src_a_sel_o(src_a_sel), .src_b_sel_o(src_b_sel),
        .imm_o(imm), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .rf_we_o(rf_we), .wb_sel_o(wb_sel), .pc_o(pc), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s obs=%h exp=<empty scoreboard>", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (e.tag == tag && obs === e.v) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h (%s)", tag, obs, e.v, e.tag);
        end
    endtask

    task automatic fetch(input logic [31:0] w);
        int n = 0;
        while (!bus.imem_req && n < 8) begin
            tick();
            n++;
        end
        push("imem_req", 32'd1);
        push("imem_addr", mpc);
        chk("imem_req", {31'b0, bus.imem_req});
        chk("imem_addr", bus.imem_addr);
        bus.imem_rdata = w;
        bus.imem_valid = 1'b1;
        tick();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
    endtask

    // instruction that goes EXEC -> WB -> FETCH
    task automatic wb_instr(input logic [31:0] w, input logic [31:0] c, input logic [1:0] sel,
                            input logic [31:0] im, input logic [4:0] d, input logic [1:0] wsel,
                            input logic [31:0] npc);
        fetch(w);
        push("alu_c", c);
        push("src_sel", {30'b0, sel});
        push("imm", im);
        push("wb_sel", {30'b0, wsel});
        push("rf_we_wb", {31'b0, d != 5'd0});
        push("rd", {27'b0, d});
        push("pc_wb", mpc);
        push("pc_next", npc);
        push("rf_we_after", 32'd0);
        tick();
        chk("alu_c", alu_c);
        chk("src_sel", {30'b0, src_a_sel, src_b_sel});
        chk("imm", imm);
        tick();
        chk("wb_sel", {30'b0, wb_sel});
        chk("rf_we_wb", {31'b0, rf_we});
        chk("rd", {27'b0, rd});
        chk("pc_wb", pc);
        tick();
        chk("pc_next", pc);
        chk("rf_we_after", {31'b0, rf_we});
        mpc = npc;
    endtask

    task automatic branch(input logic [31:0] w, input logic z, input logic [31:0] npc);
        fetch(w);
        push("br_alu_c", 32'h63007F00);
        push("br_src_sel", 32'd0);
        push("br_imm", 32'hFFFF_FFF8);
        push("br_rf_we_exec", 32'd0);
        push("br_pc", npc);
        push("br_rf_we_next", 32'd0);
        tick();
        alu_zero = z;
        chk("br_alu_c", alu_c);
        chk("br_src_sel", {30'b0, src_a_sel, src_b_sel});
        chk("br_imm", imm);
        chk("br_rf_we_exec", {31'b0, rf_we});
        tick();
        alu_zero = 1'b0;
        chk("br_pc", pc);
        chk("br_rf_we_next", {31'b0, rf_we});
        mpc = npc;
    endtask

    initial begin
        int n, k;
        bus.imem_rdata = 32'h0;
        bus.imem_valid = 1'b0;
        bus.dmem_ready = 1'b0;
        mpc = 32'h0;

        // reset held for two cycles
        tick();
        tick();
        push("rst_pc", 32'h0);
        push("rst_imem_req", 32'd0);
        push("rst_dmem_req", 32'd0);
        push("rst_illegal", 32'd0);
        push("rst_alu_c", 32'd0);
        push("rst_rf_we", 32'd0);
        chk("rst_pc", pc);
        chk("rst_imem_req", {31'b0, bus.imem_req});
        chk("rst_dmem_req", {31'b0, bus.dmem_req});
        chk("rst_illegal", {31'b0, illegal});
        chk("rst_alu_c", alu_c);
        chk("rst_rf_we", {31'b0, rf_we});
        rst_n = 1'b1;
        tick();
        push("req_rise", 32'd1);
        chk("req_rise", {31'b0, bus.imem_req});

        // ADDI x1,x0,5 ; SUB x3,x1,x2 ; ADD x3,x1,x2 ; NOP (rd=0)
        wb_instr(32'h0050_0093, 32'h1305_0000, 2'b01, 32'd5, 5'd1, 2'b00, 32'h04);
        wb_instr(32'h4020_81B3, 32'h3302_2000, 2'b00, 32'd0, 5'd3, 2'b00, 32'h08);
        wb_instr(32'h0020_81B3, 32'h3302_0000, 2'b00, 32'd0, 5'd3, 2'b00, 32'h0C);
        wb_instr(32'h0000_0013, 32'h1300_0000, 2'b01, 32'd0, 5'd0, 2'b00, 32'h10);

        // BEQ -8 taken from 0x10, JAL x5,+8 back to 0x10, BEQ not taken
        branch(32'hFE00_0CE3, 1'b1, 32'h08);
        wb_instr(32'h0080_02EF, 32'h6F08_0080, 2'b11, 32'd8, 5'd5, 2'b10, 32'h10);
        branch(32'hFE00_0CE3, 1'b0, 32'h14);

        // LW x6,4(x1) with three wait cycles
        fetch(32'h0040_A303);
        push("lw_alu_c", 32'h0304_0082);
        push("lw_imm", 32'd4);
        push("lw_we", 32'd0);
        push("lw_req_cycles", 32'd4);
        push("lw_wb_sel", 32'd1);
        push("lw_rf_we", 32'd1);
        push("lw_rd", 32'd6);
        push("lw_pc_next", 32'h18);
        push("lw_rf_we_after", 32'd0);
        tick();
        chk("lw_alu_c", alu_c);
        chk("lw_imm", imm);
        tick();
        chk("lw_we", {31'b0, bus.dmem_we});
        n = 0;
        k = 0;
        while (bus.dmem_req && k < 20) begin
            n++;
            k++;
            bus.dmem_ready = (n == 4);
            tick();
        end
        bus.dmem_ready = 1'b0;
        chk("lw_req_cycles", n);
        chk("lw_wb_sel", {30'b0, wb_sel});
        chk("lw_rf_we", {31'b0, rf_we});
        chk("lw_rd", {27'b0, rd});
        tick();
        chk("lw_pc_next", pc);
        chk("lw_rf_we_after", {31'b0, rf_we});
        mpc = 32'h18;

        // SW x2,8(x1), ready at once
        fetch(32'h0020_A423);
        push("sw_alu_c", 32'h2302_0082);
        push("sw_imm", 32'd8);
        push("sw_req", 32'd1);
        push("sw_we", 32'd1);
        push("sw_pc_next", 32'h1C);
        push("sw_rf_we", 32'd0);
        tick();
        chk("sw_alu_c", alu_c);
        chk("sw_imm", imm);
        tick();
        chk("sw_req", {31'b0, bus.dmem_req});
        chk("sw_we", {31'b0, bus.dmem_we});
        bus.dmem_ready = 1'b1;
        tick();
        bus.dmem_ready = 1'b0;
        chk("sw_pc_next", pc);
        chk("sw_rf_we", {31'b0, rf_we});
        mpc = 32'h1C;

        // JALR x1,0(x5) with ALU result 0x41 -> 0x40 ; LUI x7,0x12345
        alu_res = 32'h41;
        wb_instr(32'h0002_80E7, 32'h6700_0080, 2'b01, 32'd0, 5'd1, 2'b10, 32'h40);
        wb_instr(32'h1234_53B7, 32'h3703_0905, 2'b01, 32'h1234_5000, 5'd7, 2'b11, 32'h44);

        // illegal opcode traps, stray imem_valid is ignored
        fetch(32'h0000_007F);
        push("trap_illegal", 32'd1);
        push("trap_imem_req", 32'd0);
        push("trap_dmem_req", 32'd0);
        push("trap_pc", 32'h44);
        bus.imem_valid = 1'b1;
        repeat (6) tick();
        bus.imem_valid = 1'b0;
        chk("trap_illegal", {31'b0, illegal});
        chk("trap_imem_req", {31'b0, bus.imem_req});
        chk("trap_dmem_req", {31'b0, bus.dmem_req});
        chk("trap_pc", pc);

        // reset during a held load request
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mpc = 32'h0;
        push("rst2_illegal", 32'd0);
        chk("rst2_illegal", {31'b0, illegal});
        fetch(32'h0040_A303);
        tick();
        tick();
        push("mid_req", 32'd1);
        push("mid_req_drop", 32'd0);
        push("mid_pc", 32'h0);
        push("mid_late_ready", 32'd0);
        push("mid_imem_req", 32'd1);
        chk("mid_req", {31'b0, bus.dmem_req});
        rst_n = 1'b0;
        tick();
        chk("mid_req_drop", {31'b0, bus.dmem_req});
        chk("mid_pc", pc);
        bus.dmem_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        bus.dmem_ready = 1'b0;
        chk("mid_late_ready", {31'b0, bus.dmem_req});
        chk("mid_imem_req", {31'b0, bus.imem_req});

        // pc wrap: jump to 0xFFFF_FFFC, then a NOP wraps to 0
        alu_res = 32'hFFFF_FFFC;
        wb_instr(32'h0002_8067, 32'h6700_0080, 2'b01, 32'd0, 5'd0, 2'b10, 32'hFFFF_FFFC);
        wb_instr(32'h0000_0013, 32'h1300_0000, 2'b01, 32'd0, 5'd0, 2'b00, 32'h0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain obs=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
